display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 7, giving the segment pattern width per digit.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, giving the blanking clocks per digit slot (legal range >= 1).
REQ-003 SHALL have parameter SHOW_CYCLES, default 50000, giving the lit clocks per digit slot (legal range >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-006 SHALL have ports seg_a, seg_b, seg_c, seg_d, input, DATA_WIDTH each: the patterns for digits 0..3.
REQ-007 SHALL have port digit_mask, input, 4 bits: per-digit lit enable, bit n = digit n.
REQ-008 SHALL have port update_req, input, 1 bit: a request to capture seg_a..seg_d at the next frame boundary.
REQ-009 SHALL have port data_out, output, DATA_WIDTH: the pattern of the current digit, feeding the downstream 1-to-4 demux data input.
REQ-010 SHALL have port select, output, 2 bits: the current digit index, feeding the demux select.
REQ-011 SHALL have port enable, output, 1 bit: the lit strobe, feeding the demux enable.
REQ-012 SHALL have port frame_done, output, 1 bit: a one-clock pulse at the 3->0 wrap.

Function
REQ-013 SHALL implement a two-state FSM, BLANK and SHOW, with a slot counter cnt and a 2-bit select register.
REQ-014 In BLANK, cnt SHALL count 0..BLANK_CYCLES-1; at BLANK_CYCLES-1, cnt SHALL go to 0 and state SHALL go to SHOW.
REQ-015 In SHOW, cnt SHALL count 0..SHOW_CYCLES-1; at SHOW_CYCLES-1, cnt SHALL go to 0, state SHALL go to BLANK, and select SHALL increment, wrapping 3->0.
REQ-016 select SHALL change only on the SHOW->BLANK transition, so it never changes while enable=1.
REQ-017 enable SHALL be a registered output equal to 1 exactly in cycles where state=SHOW and digit_mask[select]=1, and 0 otherwise.
REQ-018 A masked digit SHALL still consume its full slot (BLANK_CYCLES+SHOW_CYCLES); the scan timing SHALL be independent of digit_mask.
REQ-019 Frame period SHALL be 4*(BLANK_CYCLES+SHOW_CYCLES) clocks.
REQ-020 A frame-boundary cycle SHALL be any cycle with state=BLANK, select=0 and cnt=0, including the first cycle after reset release.
REQ-021 Four shadow registers SHALL hold the displayed patterns; data_out SHALL be registered as shadow[select] every cycle, giving one cycle of latency, hidden by blanking.
REQ-022 update_req=1 SHALL set a pending flag; on a frame-boundary cycle with pending=1, all four shadows SHALL load from seg_a..seg_d and pending SHALL clear.
REQ-023 update_req=1 coincident with a frame-boundary cycle SHALL load that cycle's inputs and leave pending=0.
REQ-024 seg_a..seg_d changes without update_req SHALL never reach data_out (no mid-frame tearing).
REQ-025 frame_done SHALL be 1 for exactly the frame-boundary cycles reached by a 3->0 wrap, and never in the first cycle after reset.
REQ-026 data_out SHALL be bit-width preserving: no truncation or extension of patterns.

Reset
REQ-027 While rst_n=0 at a clock edge: state=BLANK, cnt=0, select=0, enable=0, data_out=0, frame_done=0, and all shadows=0.
REQ-028 Reset SHALL set pending=1, so the first boundary after release loads the inputs.
REQ-029 Reset asserted mid-slot, including during SHOW, SHALL force enable=0 on the next edge and abandon the slot; after release the scan SHALL restart at select 0 in BLANK.

Verification (BLANK_CYCLES=2, SHOW_CYCLES=3; cycle 0 = first edge with rst_n=1)
REQ-030 Reset: rst_n=0 for 3 cycles with seg_*=7'h7F and digit_mask=4'hF -> select=0, enable=0, data_out=0, frame_done=0 throughout.
REQ-031 Scan order: seg_a..seg_d=7'h01/02/04/08, digit_mask=4'hF, release -> the bench checks, in order:
  - enable=1 in cycles 2-4 with select=0, data_out=7'h01;
  - enable=1 in cycles 7-9 with select=1, data_out=7'h02;
  - enable=1 in cycles 12-14 with select=2, data_out=7'h04;
  - enable=1 in cycles 17-19 with select=3, data_out=7'h08;
  - frame_done=1 only in cycle 20.
REQ-032 Masking: digit_mask=4'b1010 -> the bench checks:
  - enable=1 only in cycles 7-9 and 17-19;
  - select still sequences 0,1,2,3 with unchanged timing.
REQ-033 Tearing: set seg_a=7'h40 at cycle 6 without update_req -> data_out=7'h01 in cycles 22-24; pulse update_req at cycle 25 -> data_out=7'h40 in cycles 42-44.
REQ-034 Mid-operation reset: rst_n=0 at cycle 13 (select=2, SHOW) -> enable=0 and select=0 on the next edge; after release, the first boundary reloads the shadows.
REQ-035 Coincident update: update_req=1 at boundary cycle 20 with seg_b=7'h11 -> data_out=7'h11 in cycles 27-29; later seg_b changes without a request are not displayed at cycle 47.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner: blank/show slot timing per digit,
// frame-synchronous pattern capture so the displayed frame never tears.
module display_scan_ctrl #(
    parameter int DATA_WIDTH   = 7,
    parameter int BLANK_CYCLES = 1000,
    parameter int SHOW_CYCLES  = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] seg_a,
    input  logic [DATA_WIDTH-1:0] seg_b,
    input  logic [DATA_WIDTH-1:0] seg_c,
    input  logic [DATA_WIDTH-1:0] seg_d,
    input  logic [3:0]            digit_mask,
    input  logic                  update_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            select,
    output logic                  enable,
    output logic                  frame_done
);

    localparam int MAX_CYC = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic [1:0]            r_sel;
    logic [1:0]            w_sel_nx;
    logic                  r_pending;
    logic                  r_enable;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_shadow [4];
    logic                  w_boundary;
    logic                  w_load;
    logic                  w_en_nx;
    logic                  w_fd_nx;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_sel_nx   = r_sel;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_cnt == SHOW_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_BLANK;
                    w_sel_nx   = r_sel + 2'd1;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = ST_BLANK;
            end
        endcase
    end

    // enable and frame_done are decoded from the next state so the registered
    // outputs line up with the cycle in which that state is current.
    always_comb begin
        w_en_nx    = (w_state_nx == ST_SHOW) && digit_mask[w_sel_nx];
        w_fd_nx    = (r_state == ST_SHOW) && (r_sel == 2'd3) && (r_cnt == SHOW_LAST);
        w_boundary = (r_state == ST_BLANK) && (r_sel == 2'd0) && (r_cnt == '0);
        w_load     = w_boundary && (r_pending || update_req);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_pending    <= 1'b1;
            r_enable     <= 1'b0;
            r_frame_done <= 1'b0;
            r_data       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_sel        <= w_sel_nx;
            r_enable     <= w_en_nx;
            r_frame_done <= w_fd_nx;
            r_data       <= r_shadow[r_sel];
            if (w_load) begin
                r_shadow[0] <= seg_a;
                r_shadow[1] <= seg_b;
                r_shadow[2] <= seg_c;
                r_shadow[3] <= seg_d;
                r_pending   <= 1'b0;
            end else if (update_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign data_out   = r_data;
    assign select     = r_sel;
    assign enable     = r_enable;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: cycle model plus spot-check table feed a
// scoreboard queue, drained and compared every cycle.
module tb_display_scan_ctrl;

    localparam int DW    = 7;
    localparam int BC    = 2;
    localparam int SC    = 3;
    localparam int SLOT  = BC + SC;
    localparam int FRAME = 4 * SLOT;
    localparam int NVEC  = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] seg_a = '0, seg_b = '0, seg_c = '0, seg_d = '0;
    logic [3:0]    digit_mask = 4'hF;
    logic          update_req = 1'b0;
    logic [DW-1:0] data_out;
    logic [1:0]    select;
    logic          enable;
    logic          frame_done;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DATA_WIDTH  (DW),
        .BLANK_CYCLES(BC),
        .SHOW_CYCLES (SC)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_a     (seg_a),
        .seg_b     (seg_b),
        .seg_c     (seg_c),
        .seg_d     (seg_d),
        .digit_mask(digit_mask),
        .update_req(update_req),
        .data_out  (data_out),
        .select    (select),
        .enable    (enable),
        .frame_done(frame_done)
    );

    typedef struct {
        int            seq;
        int            cyc;
        logic [1:0]    sel;
        logic          en;
        logic          fd;
        logic          chk_d;
        logic [DW-1:0] data;
    } vec_t;

    typedef struct {
        int            src;
        int            seq;
        int            cyc;
        logic [1:0]    sel;
        logic          en;
        logic          fd;
        logic          chk_d;
        logic [DW-1:0] data;
    } exp_t;

    vec_t          tbl [NVEC];
    exp_t          sb [$];
    logic [DW-1:0] m_sh [4];
    logic          m_pend;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string nm, input int seq, input int cyc,
                       input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s seq=%0d cyc=%0d got=0x%0h want=0x%0h", nm, seq, cyc, got, want);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("reset_select", -1, 0, 32'(select), 0);
            chk("reset_enable", -1, 0, 32'(enable), 0);
            chk("reset_data", -1, 0, 32'(data_out), 0);
            chk("reset_frame_done", -1, 0, 32'(frame_done), 0);
        end
    endtask

    task automatic apply_stim(input int seq, input int k);
        case (seq)
            2: begin
                if (k == 6)  seg_a = 7'h40;
                if (k == 25) update_req = 1'b1;
                if (k == 26) update_req = 1'b0;
            end
            3: if (k == 13) rst_n = 1'b0;
            5: begin
                if (k == 20) begin seg_b = 7'h11; update_req = 1'b1; end
                if (k == 21) update_req = 1'b0;
                if (k == 35) seg_b = 7'h22;
            end
            default: ;
        endcase
    endtask

    task automatic run_seq(input int seq, input int ncyc);
        exp_t e;
        int   slot;
        for (int i = 0; i < 4; i++) m_sh[i] = '0;
        m_pend = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            apply_stim(seq, k);
            slot    = (k / SLOT) % 4;
            e.src   = 0;
            e.seq   = seq;
            e.cyc   = k;
            e.sel   = 2'(slot);
            e.chk_d = (k % SLOT) >= BC;
            e.en    = e.chk_d && digit_mask[slot];
            e.fd    = (k > 0) && (k % FRAME == 0);
            e.data  = m_sh[slot];
            sb.push_back(e);
            for (int j = 0; j < NVEC; j++) begin
                if (tbl[j].seq == seq && tbl[j].cyc == k) begin
                    e.src   = 1;
                    e.sel   = tbl[j].sel;
                    e.en    = tbl[j].en;
                    e.fd    = tbl[j].fd;
                    e.chk_d = tbl[j].chk_d;
                    e.data  = tbl[j].data;
                    sb.push_back(e);
                end
            end
            // Frame-boundary capture in the model, seen by the display from k+2.
            if (k % FRAME == 0 && (m_pend || update_req)) begin
                m_sh[0] = seg_a; m_sh[1] = seg_b; m_sh[2] = seg_c; m_sh[3] = seg_d;
                m_pend  = 1'b0;
            end else if (update_req) begin
                m_pend = 1'b1;
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.src ? "tbl_select" : "mdl_select", e.seq, e.cyc, 32'(select), 32'(e.sel));
                chk(e.src ? "tbl_enable" : "mdl_enable", e.seq, e.cyc, 32'(enable), 32'(e.en));
                chk(e.src ? "tbl_frame_done" : "mdl_frame_done", e.seq, e.cyc,
                    32'(frame_done), 32'(e.fd));
                if (e.chk_d)
                    chk(e.src ? "tbl_data" : "mdl_data", e.seq, e.cyc, 32'(data_out), 32'(e.data));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 0,  2'd0, 1'b0, 1'b0, 1'b0, 7'h00};
        tbl[1]  = '{0, 2,  2'd0, 1'b1, 1'b0, 1'b1, 7'h01};
        tbl[2]  = '{0, 4,  2'd0, 1'b1, 1'b0, 1'b1, 7'h01};
        tbl[3]  = '{0, 5,  2'd1, 1'b0, 1'b0, 1'b0, 7'h00};
        tbl[4]  = '{0, 7,  2'd1, 1'b1, 1'b0, 1'b1, 7'h02};
        tbl[5]  = '{0, 9,  2'd1, 1'b1, 1'b0, 1'b1, 7'h02};
        tbl[6]  = '{0, 12, 2'd2, 1'b1, 1'b0, 1'b1, 7'h04};
        tbl[7]  = '{0, 14, 2'd2, 1'b1, 1'b0, 1'b1, 7'h04};
        tbl[8]  = '{0, 17, 2'd3, 1'b1, 1'b0, 1'b1, 7'h08};
        tbl[9]  = '{0, 19, 2'd3, 1'b1, 1'b0, 1'b1, 7'h08};
        tbl[10] = '{0, 20, 2'd0, 1'b0, 1'b1, 1'b0, 7'h00};
        tbl[11] = '{0, 21, 2'd0, 1'b0, 1'b0, 1'b0, 7'h00};
        tbl[12] = '{1, 2,  2'd0, 1'b0, 1'b0, 1'b1, 7'h01};
        tbl[13] = '{1, 7,  2'd1, 1'b1, 1'b0, 1'b1, 7'h02};
        tbl[14] = '{1, 9,  2'd1, 1'b1, 1'b0, 1'b1, 7'h02};
        tbl[15] = '{1, 12, 2'd2, 1'b0, 1'b0, 1'b1, 7'h04};
        tbl[16] = '{1, 17, 2'd3, 1'b1, 1'b0, 1'b1, 7'h08};
        tbl[17] = '{1, 19, 2'd3, 1'b1, 1'b0, 1'b1, 7'h08};
        tbl[18] = '{2, 22, 2'd0, 1'b1, 1'b0, 1'b1, 7'h01};
        tbl[19] = '{2, 24, 2'd0, 1'b1, 1'b0, 1'b1, 7'h01};
        tbl[20] = '{2, 42, 2'd0, 1'b1, 1'b0, 1'b1, 7'h40};
        tbl[21] = '{2, 44, 2'd0, 1'b1, 1'b0, 1'b1, 7'h40};
        tbl[22] = '{4, 2,  2'd0, 1'b1, 1'b0, 1'b1, 7'h5A};
        tbl[23] = '{4, 4,  2'd0, 1'b1, 1'b0, 1'b1, 7'h5A};
        tbl[24] = '{5, 27, 2'd1, 1'b1, 1'b0, 1'b1, 7'h11};
        tbl[25] = '{5, 29, 2'd1, 1'b1, 1'b0, 1'b1, 7'h11};
        tbl[26] = '{5, 47, 2'd1, 1'b1, 1'b0, 1'b1, 7'h11};

        // Reset with all-ones patterns, then a full-mask scan.
        seg_a = 7'h7F; seg_b = 7'h7F; seg_c = 7'h7F; seg_d = 7'h7F;
        digit_mask = 4'hF;
        do_reset(3);
        seg_a = 7'h01; seg_b = 7'h02; seg_c = 7'h04; seg_d = 7'h08;
        rst_n = 1'b1;
        run_seq(0, 25);

        digit_mask = 4'b1010;
        do_reset(2);
        rst_n = 1'b1;
        run_seq(1, 25);

        seg_a = 7'h01;
        digit_mask = 4'hF;
        do_reset(2);
        rst_n = 1'b1;
        run_seq(2, 50);

        // Reset lands during SHOW of digit 2; new patterns must load after release.
        seg_a = 7'h01;
        do_reset(2);
        rst_n = 1'b1;
        run_seq(3, 14);
        @(negedge clk);
        chk("midreset_enable", 3, 14, 32'(enable), 0);
        chk("midreset_select", 3, 14, 32'(select), 0);
        chk("midreset_data", 3, 14, 32'(data_out), 0);
        seg_a = 7'h5A; seg_b = 7'h25; seg_c = 7'h33; seg_d = 7'h4C;
        do_reset(2);
        rst_n = 1'b1;
        run_seq(4, 10);

        seg_a = 7'h01; seg_b = 7'h02; seg_c = 7'h04; seg_d = 7'h08;
        do_reset(2);
        rst_n = 1'b1;
        run_seq(5, 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
